// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signals shared by the two-master AHB arbiter and its environment.
// The slave modport is the arbiter's view; the master modport drives requests.
interface ahb_bus_arbiter_if #(
  parameter int MASTER_ID_BITS = 4
);
  logic                      HBUSREQ_M1;
  logic                      HBUSREQ_M2;
  logic                      HLOCK_M1;
  logic                      HLOCK_M2;
  logic [1:0]                HTRANS;
  logic [2:0]                HBURST;
  logic                      HREADY;
  logic                      HGRANT_M1;
  logic                      HGRANT_M2;
  logic                      HGRANTDefault;
  logic [MASTER_ID_BITS-1:0] HMASTER;
  logic                      HMASTLOCK;

  modport slave (
    input  HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2,
    input  HTRANS, HBURST, HREADY,
    output HGRANT_M1, HGRANT_M2, HGRANTDefault, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2,
    output HTRANS, HBURST, HREADY,
    input  HGRANT_M1, HGRANT_M2, HGRANTDefault, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter with default master; burst/lock aware, hand-over gated on HREADY.
// Define AHB_ARB_RR_EN to arbitrate M1/M2 round-robin instead of fixed priority M2 > M1.
module ahb_bus_arbiter #(
  parameter int MASTER_ID_BITS = 4,
  parameter int ID_DEFAULT     = 0,
  parameter int ID_M1          = 1,
  parameter int ID_M2          = 2
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [2:0] GNT_DEF = 3'b001;
  localparam logic [2:0] GNT_M1  = 3'b010;
  localparam logic [2:0] GNT_M2  = 3'b100;

  logic [2:0]                grant_reg;   // {M2, M1, Default}, one-hot
  logic [3:0]                beat_cnt;
  logic                      lock_reg;
  logic [MASTER_ID_BITS-1:0] hmaster_q;
  logic                      hmastlock_q;
`ifdef AHB_ARB_RR_EN
  logic                      last_gnt;    // 0: M1 granted last, 1: M2 granted last
`endif

  logic [3:0]                next_beat_cnt;
  logic                      hlock_granted;
  logic                      arb_en;
  logic [2:0]                winner;

  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      3'd6, 3'd7: burst_len_m1 = 4'd15;
      default:    burst_len_m1 = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] cnt);
    sat_dec = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  endfunction

  function automatic logic [MASTER_ID_BITS-1:0] owner_id(input logic [2:0] gnt);
    case (gnt)
      GNT_M1:  owner_id = MASTER_ID_BITS'(ID_M1);
      GNT_M2:  owner_id = MASTER_ID_BITS'(ID_M2);
      default: owner_id = MASTER_ID_BITS'(ID_DEFAULT);
    endcase
  endfunction

  // Arbitration decision for this edge
  always_comb begin
    hlock_granted = (grant_reg[1] & bus.HLOCK_M1) | (grant_reg[2] & bus.HLOCK_M2);

    next_beat_cnt = beat_cnt;
    if (bus.HREADY) begin
      case (bus.HTRANS)
        TRANS_NONSEQ: next_beat_cnt = burst_len_m1(bus.HBURST);
        TRANS_SEQ:    next_beat_cnt = sat_dec(beat_cnt);
        default:      next_beat_cnt = beat_cnt;
      endcase
    end

    // Opening at count<=1 moves the grant one beat ahead of the ownership change.
    arb_en = bus.HREADY & ~lock_reg & ~hlock_granted & (next_beat_cnt <= 4'd1);

    if (bus.HBUSREQ_M2)      winner = GNT_M2;
    else if (bus.HBUSREQ_M1) winner = GNT_M1;
    else                     winner = GNT_DEF;
`ifdef AHB_ARB_RR_EN
    if (bus.HBUSREQ_M1 && bus.HBUSREQ_M2)
      winner = last_gnt ? GNT_M1 : GNT_M2;
`endif
  end

  // Registered grant, burst/lock tracking and address-phase ownership
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_reg   <= GNT_DEF;
      beat_cnt    <= 4'd0;
      lock_reg    <= 1'b0;
      hmaster_q   <= MASTER_ID_BITS'(ID_DEFAULT);
      hmastlock_q <= 1'b0;
`ifdef AHB_ARB_RR_EN
      last_gnt    <= 1'b0;
`endif
    end else begin
      if (bus.HREADY) begin
        beat_cnt    <= next_beat_cnt;
        lock_reg    <= hlock_granted;
        hmaster_q   <= owner_id(grant_reg);
        hmastlock_q <= hlock_granted;
      end
      if (arb_en) begin
        grant_reg <= winner;
`ifdef AHB_ARB_RR_EN
        if (!winner[0]) last_gnt <= winner[2];
`endif
      end
    end
  end

  assign bus.HGRANTDefault = grant_reg[0];
  assign bus.HGRANT_M1     = grant_reg[1];
  assign bus.HGRANT_M2     = grant_reg[2];
  assign bus.HMASTER       = hmaster_q;
  assign bus.HMASTLOCK     = hmastlock_q;

endmodule
